// File: rtl/cpu65xx_status_register_pkg.sv
// Shared 65xx microcode constants: flag-op codes, P bit positions and the stored-flag type.
// Also provides the helper that builds the 8-bit status byte from the stored flags.
package cpu65xx_status_register_pkg;

    localparam int unsigned FLAG_OP_W = 3;

    localparam logic [FLAG_OP_W-1:0] FLAG_OP_NONE = 3'd0;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_CLC  = 3'd1;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_SEC  = 3'd2;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_CLI  = 3'd3;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_SEI  = 3'd4;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_CLD  = 3'd5;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_SED  = 3'd6;
    localparam logic [FLAG_OP_W-1:0] FLAG_OP_CLV  = 3'd7;

    // Bit positions inside the status byte
    localparam int unsigned P_BIT_C = 0;
    localparam int unsigned P_BIT_Z = 1;
    localparam int unsigned P_BIT_I = 2;
    localparam int unsigned P_BIT_D = 3;
    localparam int unsigned P_BIT_B = 4;
    localparam int unsigned P_BIT_U = 5;
    localparam int unsigned P_BIT_V = 6;
    localparam int unsigned P_BIT_N = 7;

    // Positions inside the {N,V,Z,C} ALU write-enable vector
    localparam int unsigned FW_C = 0;
    localparam int unsigned FW_Z = 1;
    localparam int unsigned FW_V = 2;
    localparam int unsigned FW_N = 3;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    function automatic logic [7:0] pack_status(input flags_t f, input logic b_bit);
        logic [7:0] p;
        p          = '0;
        p[P_BIT_N] = f.n;
        p[P_BIT_V] = f.v;
        p[P_BIT_U] = 1'b1;
        p[P_BIT_B] = b_bit;
        p[P_BIT_D] = f.d;
        p[P_BIT_I] = f.i;
        p[P_BIT_Z] = f.z;
        p[P_BIT_C] = f.c;
        return p;
    endfunction

endpackage

// File: rtl/cpu65xx_status_register_if.sv
// Microcode/ALU-facing bundle of the status register. The sequencer side is the master,
// the status register itself is the slave.
interface cpu65xx_status_register_if
    import cpu65xx_status_register_pkg::*;
;
    logic                 advance;
    logic                 aluCarryOut;
    logic                 aluOverflowOut;
    logic                 aluZero;
    logic                 aluNegative;
    logic [3:0]           flagWrite;
    logic [FLAG_OP_W-1:0] flagOp;
    logic                 loadFromBus;
    logic [7:0]           dataIn;
    logic                 interruptEntry;
    logic                 instrBoundary;
    logic                 soPin_n;
    logic                 pushIsBrk;
    logic [7:0]           pOut;
    logic [7:0]           pushOut;
    logic                 carryToAlu;
    logic                 overflowToAlu;
    logic                 decimalToAlu;
    logic                 irqMask;

    modport master (
        output advance, aluCarryOut, aluOverflowOut, aluZero, aluNegative, flagWrite, flagOp,
               loadFromBus, dataIn, interruptEntry, instrBoundary, soPin_n, pushIsBrk,
        input  pOut, pushOut, carryToAlu, overflowToAlu, decimalToAlu, irqMask
    );

    modport slave (
        input  advance, aluCarryOut, aluOverflowOut, aluZero, aluNegative, flagWrite, flagOp,
               loadFromBus, dataIn, interruptEntry, instrBoundary, soPin_n, pushIsBrk,
        output pOut, pushOut, carryToAlu, overflowToAlu, decimalToAlu, irqMask
    );

endinterface

// File: rtl/cpu65xx_so_edge_detect.sv
// Synchronises the asynchronous SO pin and latches a falling edge until the core consumes it.
// The latch runs regardless of the microcode cycle enable so no edge is lost while stalled.
module cpu65xx_so_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic so_pin_n_i,
    input  logic consume_i,
    output logic pending_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       prev_q;
    logic       prev_d;
    logic       pending_q;
    logic       pending_d;
    logic       fell;

    always_comb begin
        sync_d = {sync_q[0], so_pin_n_i};
        prev_d = sync_q[1];
        fell   = prev_q & ~sync_q[1];
        // A new edge wins over a same-cycle consume
        pending_d = fell | (pending_q & ~consume_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cpu65xx_status_register.sv
// 65xx processor status register: six stored flags plus the delayed IRQ mask, updated from
// the ALU, flag instructions, stack pulls, interrupt entry and the SO pin.
module cpu65xx_status_register
    import cpu65xx_status_register_pkg::*;
#(
    parameter bit CMOS_CLEAR_D = 1'b0,
    parameter bit RESET_D      = 1'b0
) (
    input logic                       clk,
    input logic                       reset,
    cpu65xx_status_register_if.slave  bus
);

    flags_t flags_q;
    flags_t flags_d;
    logic   irq_mask_q;
    logic   irq_mask_d;
    logic   so_pending;

    // Bits 5/4 of a pulled byte are never stored
    logic   unused_data_bits;
    assign unused_data_bits = ^bus.dataIn[P_BIT_U:P_BIT_B];

    cpu65xx_so_edge_detect u_so_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .so_pin_n_i (bus.soPin_n),
        .consume_i  (bus.advance),
        .pending_o  (so_pending)
    );

    // Sources are applied lowest priority first so each later one overrides per bit
    always_comb begin
        flags_d    = flags_q;
        irq_mask_d = irq_mask_q;
        if (bus.advance) begin
            if (bus.flagWrite[FW_N]) flags_d.n = bus.aluNegative;
            if (bus.flagWrite[FW_V]) flags_d.v = bus.aluOverflowOut;
            if (bus.flagWrite[FW_Z]) flags_d.z = bus.aluZero;
            if (bus.flagWrite[FW_C]) flags_d.c = bus.aluCarryOut;

            case (bus.flagOp)
                FLAG_OP_CLC: flags_d.c = 1'b0;
                FLAG_OP_SEC: flags_d.c = 1'b1;
                FLAG_OP_CLI: flags_d.i = 1'b0;
                FLAG_OP_SEI: flags_d.i = 1'b1;
                FLAG_OP_CLD: flags_d.d = 1'b0;
                FLAG_OP_SED: flags_d.d = 1'b1;
                FLAG_OP_CLV: flags_d.v = 1'b0;
                default:     ;
            endcase

            if (bus.interruptEntry) begin
                flags_d.i = 1'b1;
                if (CMOS_CLEAR_D) flags_d.d = 1'b0;
            end

            if (bus.loadFromBus) begin
                flags_d.n = bus.dataIn[P_BIT_N];
                flags_d.v = bus.dataIn[P_BIT_V];
                flags_d.d = bus.dataIn[P_BIT_D];
                flags_d.i = bus.dataIn[P_BIT_I];
                flags_d.z = bus.dataIn[P_BIT_Z];
                flags_d.c = bus.dataIn[P_BIT_C];
            end

            if (so_pending) flags_d.v = 1'b1;

            // IRQ sampling sees I as it was before this cycle's update
            if (bus.instrBoundary) irq_mask_d = flags_q.i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q    <= '{n: 1'b0, v: 1'b0, d: RESET_D, i: 1'b1, z: 1'b0, c: 1'b0};
            irq_mask_q <= 1'b1;
        end else begin
            flags_q    <= flags_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign bus.pOut          = pack_status(flags_q, 1'b1);
    assign bus.pushOut       = pack_status(flags_q, bus.pushIsBrk);
    assign bus.carryToAlu    = flags_q.c;
    assign bus.overflowToAlu = flags_q.v;
    assign bus.decimalToAlu  = flags_q.d;
    assign bus.irqMask       = irq_mask_q;

endmodule

// File: tb/tb_cpu65xx_status_register.sv
// Directed bench for cpu65xx_status_register: an NMOS instance (RESET_D=0) and a CMOS
// instance (CMOS_CLEAR_D=1, RESET_D=1) share clock and reset.
module tb_cpu65xx_status_register;
    import cpu65xx_status_register_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cpu65xx_status_register_if bus0 ();
    cpu65xx_status_register_if bus1 ();

    cpu65xx_status_register #(.CMOS_CLEAR_D(1'b0), .RESET_D(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    cpu65xx_status_register #(.CMOS_CLEAR_D(1'b1), .RESET_D(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quiet all control inputs; the SO pins are left where they are
    task automatic idle();
        bus0.advance = 0; bus0.aluCarryOut = 0; bus0.aluOverflowOut = 0; bus0.aluZero = 0;
        bus0.aluNegative = 0; bus0.flagWrite = 4'h0; bus0.flagOp = FLAG_OP_NONE;
        bus0.loadFromBus = 0; bus0.dataIn = 8'h00; bus0.interruptEntry = 0;
        bus0.instrBoundary = 0; bus0.pushIsBrk = 0;
        bus1.advance = 0; bus1.aluCarryOut = 0; bus1.aluOverflowOut = 0; bus1.aluZero = 0;
        bus1.aluNegative = 0; bus1.flagWrite = 4'h0; bus1.flagOp = FLAG_OP_NONE;
        bus1.loadFromBus = 0; bus1.dataIn = 8'h00; bus1.interruptEntry = 0;
        bus1.instrBoundary = 0; bus1.pushIsBrk = 0;
    endtask

    task automatic test_reset();
        bus0.soPin_n = 1'b1;
        bus1.soPin_n = 1'b1;
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (bus0.pOut !== 8'h34) begin
            errors++; $display("FAIL reset_p0: got %h want %h", bus0.pOut, 8'h34);
        end
        checks++;
        if (bus0.irqMask !== 1'b1) begin
            errors++; $display("FAIL reset_irqmask0: got %b want 1", bus0.irqMask);
        end
        checks++;
        if (bus0.pushOut !== 8'h24) begin
            errors++; $display("FAIL reset_push0: got %h want %h", bus0.pushOut, 8'h24);
        end
        checks++;
        if (bus1.pOut !== 8'h3C) begin
            errors++; $display("FAIL reset_p1_resetd: got %h want %h", bus1.pOut, 8'h3C);
        end
    endtask

    task automatic test_flag_write();
        idle();
        bus0.advance = 1; bus0.flagWrite = 4'b1011;
        bus0.aluNegative = 1; bus0.aluOverflowOut = 1; bus0.aluZero = 0; bus0.aluCarryOut = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'hB5) begin
            errors++; $display("FAIL flagwrite_p: got %h want %h", bus0.pOut, 8'hB5);
        end
        checks++;
        if (bus0.carryToAlu !== 1'b1 || bus0.overflowToAlu !== 1'b0) begin
            errors++;
            $display("FAIL flagwrite_cv: got c=%b v=%b want c=1 v=0",
                     bus0.carryToAlu, bus0.overflowToAlu);
        end
        // Stalled cycle: everything including irqMask frozen
        bus0.flagWrite = 4'hF; bus0.flagOp = FLAG_OP_SED; bus0.instrBoundary = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'hB5 || bus0.irqMask !== 1'b1) begin
            errors++;
            $display("FAIL freeze: got p=%h m=%b want p=b5 m=1", bus0.pOut, bus0.irqMask);
        end
    endtask

    task automatic test_load_priority();
        idle();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h00; bus0.flagOp = FLAG_OP_SEC;
        bus0.flagWrite = 4'hF; bus0.aluNegative = 1; bus0.aluOverflowOut = 1;
        bus0.aluZero = 1; bus0.aluCarryOut = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h30) begin
            errors++; $display("FAIL load_over_all: got %h want %h", bus0.pOut, 8'h30);
        end
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'hCF;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'hFF) begin
            errors++; $display("FAIL load_bits54: got %h want %h", bus0.pOut, 8'hFF);
        end
        checks++;
        if (bus0.pushOut !== 8'hEF) begin
            errors++; $display("FAIL push_irq: got %h want %h", bus0.pushOut, 8'hEF);
        end
        bus0.pushIsBrk = 1;
        #1;
        checks++;
        if (bus0.pushOut !== 8'hFF) begin
            errors++; $display("FAIL push_brk: got %h want %h", bus0.pushOut, 8'hFF);
        end
        idle();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h00; bus0.interruptEntry = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h30) begin
            errors++; $display("FAIL load_over_int: got %h want %h", bus0.pOut, 8'h30);
        end
    endtask

    task automatic test_flag_ops();
        logic [2:0] ops [6];
        logic [7:0] exp [6];
        ops = '{FLAG_OP_SEC, FLAG_OP_SED, FLAG_OP_SEI, FLAG_OP_CLC, FLAG_OP_CLD, FLAG_OP_CLI};
        exp = '{8'h31, 8'h39, 8'h3D, 8'h3C, 8'h34, 8'h30};
        for (int k = 0; k < 6; k++) begin
            idle();
            bus0.advance = 1; bus0.flagOp = ops[k];
            step();
            checks++;
            if (bus0.pOut !== exp[k]) begin
                errors++; $display("FAIL flagop_%0d: got %h want %h", k, bus0.pOut, exp[k]);
            end
        end
        idle();
        bus0.advance = 1; bus0.flagOp = FLAG_OP_CLC; bus0.flagWrite = 4'b0001;
        bus0.aluCarryOut = 1;
        step();
        checks++;
        if (bus0.pOut !== 8'h30) begin
            errors++; $display("FAIL clc_over_alu: got %h want %h", bus0.pOut, 8'h30);
        end
        idle();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h40;
        step();
        idle();
        bus0.advance = 1; bus0.flagOp = FLAG_OP_CLV; bus0.flagWrite = 4'b0100;
        bus0.aluOverflowOut = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h30) begin
            errors++; $display("FAIL clv_over_alu: got %h want %h", bus0.pOut, 8'h30);
        end
    endtask

    task automatic test_irq_mask();
        idle();
        bus0.advance = 1; bus0.flagOp = FLAG_OP_SEI; bus0.instrBoundary = 1;
        step();
        checks++;
        if (bus0.irqMask !== 1'b0 || bus0.pOut !== 8'h34) begin
            errors++;
            $display("FAIL irq_sei: got m=%b p=%h want m=0 p=34", bus0.irqMask, bus0.pOut);
        end
        bus0.flagOp = FLAG_OP_CLI;
        step();
        checks++;
        if (bus0.irqMask !== 1'b1 || bus0.pOut !== 8'h30) begin
            errors++;
            $display("FAIL irq_cli: got m=%b p=%h want m=1 p=30", bus0.irqMask, bus0.pOut);
        end
        bus0.flagOp = FLAG_OP_NONE;
        step();
        idle();
        checks++;
        if (bus0.irqMask !== 1'b0) begin
            errors++; $display("FAIL irq_next: got %b want 0", bus0.irqMask);
        end
    endtask

    task automatic test_so();
        idle();
        bus0.soPin_n = 0;
        repeat (5) step();
        checks++;
        if (bus0.overflowToAlu !== 1'b0) begin
            errors++; $display("FAIL so_stalled: got %b want 0", bus0.overflowToAlu);
        end
        bus0.advance = 1; bus0.flagOp = FLAG_OP_CLV;
        step();
        checks++;
        if (bus0.pOut !== 8'h70) begin
            errors++; $display("FAIL so_over_clv: got %h want %h", bus0.pOut, 8'h70);
        end
        bus0.flagOp = FLAG_OP_NONE;
        step();
        bus0.flagOp = FLAG_OP_CLV;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h30) begin
            errors++; $display("FAIL so_consumed: got %h want %h", bus0.pOut, 8'h30);
        end
        bus0.soPin_n = 1;
        repeat (4) step();
        bus0.soPin_n = 0;
        repeat (5) step();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h00;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h70) begin
            errors++; $display("FAIL so_over_load: got %h want %h", bus0.pOut, 8'h70);
        end
        bus0.soPin_n = 1;
        repeat (4) step();
    endtask

    task automatic test_cmos();
        idle();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h3C;
        bus1.advance = 1; bus1.loadFromBus = 1; bus1.dataIn = 8'h3C;
        step();
        idle();
        bus0.advance = 1; bus0.interruptEntry = 1;
        bus1.advance = 1; bus1.interruptEntry = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'h3C) begin
            errors++; $display("FAIL nmos_int_keeps_d: got %h want %h", bus0.pOut, 8'h3C);
        end
        checks++;
        if (bus1.pOut !== 8'h34) begin
            errors++; $display("FAIL cmos_int_clears_d: got %h want %h", bus1.pOut, 8'h34);
        end
        checks++;
        if (bus1.pushOut !== 8'h24) begin
            errors++; $display("FAIL cmos_push: got %h want %h", bus1.pushOut, 8'h24);
        end
        bus1.advance = 1; bus1.loadFromBus = 1; bus1.dataIn = 8'h3C;
        step();
        idle();
        bus1.advance = 1; bus1.interruptEntry = 1; bus1.flagOp = FLAG_OP_SED;
        step();
        idle();
        checks++;
        if (bus1.pOut !== 8'h34) begin
            errors++; $display("FAIL cmos_int_over_sed: got %h want %h", bus1.pOut, 8'h34);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        bus0.advance = 1; bus0.loadFromBus = 1; bus0.dataIn = 8'h00;
        step();
        bus0.dataIn = 8'hFF; bus0.instrBoundary = 1;
        step();
        idle();
        checks++;
        if (bus0.pOut !== 8'hFF || bus0.irqMask !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: got p=%h m=%b want p=ff m=0", bus0.pOut, bus0.irqMask);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus0.pOut !== 8'h34 || bus0.irqMask !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got p=%h m=%b want p=34 m=1", bus0.pOut, bus0.irqMask);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_flag_write();
        test_load_priority();
        test_flag_ops();
        test_irq_mask();
        test_so();
        test_cmos();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
